// File: rtl/fifo4_rr_read_sched_if.sv
// FIFO read-side and uplink signal bundle for fifo4_rr_read_sched.
// FIFO_OVF_FLAG_EN adds fifo_full and ovf_sticky.
interface fifo4_rr_read_sched_if;
    logic        arb_en;
    logic [3:0]  fifo_empty;
    logic [31:0] fifo_q0;
    logic [31:0] fifo_q1;
    logic [31:0] fifo_q2;
    logic [31:0] fifo_q3;
    logic [3:0]  fifo_rdreq;
    logic        up_ready;
    logic        data_valid;
    logic [63:0] up_data;
    logic [1:0]  grant_ch;
`ifdef FIFO_OVF_FLAG_EN
    logic [3:0]  fifo_full;
    logic [3:0]  ovf_sticky;

    modport master (
        input  arb_en, fifo_empty, fifo_q0, fifo_q1, fifo_q2, fifo_q3, up_ready, fifo_full,
        output fifo_rdreq, data_valid, up_data, grant_ch, ovf_sticky
    );
    modport slave (
        output arb_en, fifo_empty, fifo_q0, fifo_q1, fifo_q2, fifo_q3, up_ready, fifo_full,
        input  fifo_rdreq, data_valid, up_data, grant_ch, ovf_sticky
    );
`else
    modport master (
        input  arb_en, fifo_empty, fifo_q0, fifo_q1, fifo_q2, fifo_q3, up_ready,
        output fifo_rdreq, data_valid, up_data, grant_ch
    );
    modport slave (
        output arb_en, fifo_empty, fifo_q0, fifo_q1, fifo_q2, fifo_q3, up_ready,
        input  fifo_rdreq, data_valid, up_data, grant_ch
    );
`endif
endinterface

// File: rtl/fifo4_rr_read_sched.sv
// Round-robin burst reader of four channel FIFOs onto a tagged 64-bit uplink (FIFO_OVF_FLAG_EN: overflow flag).
// Latency: rdreq one cycle after grant, data_valid two cycles after rdreq; 1 word / 3 cycles steady state.
// Backpressure: the word is held in HOLD until up_ready; no FIFO read is issued while held.
module fifo4_rr_read_sched #(
    parameter logic [15:0] HDR_WORD  = 16'hA55A,
    parameter int unsigned BURST_MAX = 4
) (
    input  logic                  ch1_wrclk,
    input  logic                  rst_n,
    fifo4_rr_read_sched_if.master bus
);
    typedef enum logic [1:0] {IDLE, READ, CAPT, HOLD} state_t;

    state_t      state;
    logic [1:0]  rr_ptr;
    logic [3:0]  burst_cnt;
    logic [7:0]  seq [4];
    logic [1:0]  cand;
    logic [1:0]  pick_ch;
    logic        pick_vld;
    logic [31:0] q_sel;
    logic        ovf_bit;

    // Walk from the farthest candidate back to rr_ptr so the nearest non-empty channel wins.
    always_comb begin
        cand     = rr_ptr;
        pick_ch  = rr_ptr;
        pick_vld = 1'b0;
        for (int i = 3; i >= 0; i--) begin
            cand = rr_ptr + 2'(i);
            if (!bus.fifo_empty[cand]) begin
                pick_ch  = cand;
                pick_vld = 1'b1;
            end
        end
    end

    always_comb begin
        case (bus.grant_ch)
            2'd0:    q_sel = bus.fifo_q0;
            2'd1:    q_sel = bus.fifo_q1;
            2'd2:    q_sel = bus.fifo_q2;
            default: q_sel = bus.fifo_q3;
        endcase
    end

`ifdef FIFO_OVF_FLAG_EN
    always_ff @(posedge ch1_wrclk or negedge rst_n) begin
        if (!rst_n) bus.ovf_sticky <= '0;
        else        bus.ovf_sticky <= bus.ovf_sticky | bus.fifo_full;
    end
    assign ovf_bit = bus.ovf_sticky[bus.grant_ch];
`else
    assign ovf_bit = 1'b0;
`endif

    always_ff @(posedge ch1_wrclk or negedge rst_n) begin
        if (!rst_n) begin
            state          <= IDLE;
            rr_ptr         <= 2'd0;
            burst_cnt      <= 4'd0;
            bus.fifo_rdreq <= 4'd0;
            bus.data_valid <= 1'b0;
            bus.up_data    <= 64'd0;
            bus.grant_ch   <= 2'd0;
            for (int i = 0; i < 4; i++) seq[i] <= 8'd0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.arb_en && pick_vld) begin
                        bus.grant_ch   <= pick_ch;
                        burst_cnt      <= 4'd0;
                        bus.fifo_rdreq <= 4'b0001 << pick_ch;
                        state          <= READ;
                    end
                end
                READ: begin
                    bus.fifo_rdreq <= 4'd0;
                    state          <= CAPT;
                end
                CAPT: begin
                    bus.up_data        <= {HDR_WORD, ovf_bit, 5'd0, bus.grant_ch, seq[bus.grant_ch], q_sel};
                    bus.data_valid     <= 1'b1;
                    seq[bus.grant_ch]  <= seq[bus.grant_ch] + 8'd1;
                    burst_cnt          <= burst_cnt + 4'd1;
                    state              <= HOLD;
                end
                HOLD: begin
                    if (bus.up_ready) begin
                        bus.data_valid <= 1'b0;
                        if (bus.arb_en && (burst_cnt < 4'(BURST_MAX)) && !bus.fifo_empty[bus.grant_ch]) begin
                            bus.fifo_rdreq <= 4'b0001 << bus.grant_ch;
                            state          <= READ;
                        end else begin
                            rr_ptr <= bus.grant_ch + 2'd1;
                            state  <= IDLE;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_fifo4_rr_read_sched.sv
// Bench for fifo4_rr_read_sched: FIFO models plus a transaction-timed reference model, directed and random traffic.
module tb_fifo4_rr_read_sched;
    localparam int          BM  = 4;
    localparam logic [15:0] HDR = 16'hA55A;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    fifo4_rr_read_sched_if bus();
    fifo4_rr_read_sched #(.HDR_WORD(HDR), .BURST_MAX(BM)) dut (
        .ch1_wrclk(clk),
        .rst_n    (rst_n),
        .bus      (bus)
    );

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    // FIFO contents as seen by the DUT, and the model's own copy of expected data order
    logic [31:0] envq [4][$];
    logic [31:0] modq [4][$];
    logic [31:0] qreg [4];
    logic [31:0] pend_val [4];
    bit          pend_pop [4];

    assign bus.fifo_q0 = qreg[0];
    assign bus.fifo_q1 = qreg[1];
    assign bus.fifo_q2 = qreg[2];
    assign bus.fifo_q3 = qreg[3];

    // reference model: grant, burst, sequence and timing of expected events
    logic [1:0]  m_ptr, m_ch;
    int          m_cnt;
    logic [7:0]  m_seq [4];
    bit          m_idle, m_dv;
    int          m_idle_from, m_pend_rd, m_word_due;
    logic [63:0] m_word;
    logic [3:0]  m_rd, m_ovf, drv_emp;
    logic        drv_arb;

    // logs of what the DUT actually delivered
    logic [63:0] acc_word [$];
    int          dv_cycles, rd_cycles, rd_first, dv_first;
    logic [3:0]  rd_or;
    int          pushed;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic push(input int ch, input logic [31:0] d);
        envq[ch].push_back(d);
        modq[ch].push_back(d);
        pushed++;
    endtask

    task automatic clear_logs();
        acc_word.delete();
        dv_cycles = 0; rd_cycles = 0; rd_first = -1; dv_first = -1; rd_or = '0; pushed = 0;
    endtask

    task automatic model_step();
        logic [1:0]  c;
        bit          found;
        logic [31:0] d;
        m_rd = '0;
        if (m_pend_rd == cyc) begin
            m_rd = 4'b0001 << m_ch;
        end else if (m_idle && cyc >= m_idle_from && drv_arb) begin
            found = 1'b0;
            for (int k = 0; k < 4; k++) begin
                c = 2'(int'(m_ptr) + k);
                if (!found && !drv_emp[c]) begin
                    found = 1'b1;
                    m_ch  = c;
                end
            end
            if (found) begin
                m_idle = 1'b0;
                m_cnt  = 0;
                m_rd   = 4'b0001 << m_ch;
            end
        end
        if (m_rd != 4'd0) begin
            d = 32'hBAD0_BAD0;
            if (modq[m_ch].size() > 0) d = modq[m_ch].pop_front();
            m_word       = {HDR, 1'b0, 5'd0, m_ch, m_seq[m_ch], d};
            m_seq[m_ch]  = m_seq[m_ch] + 8'd1;
            m_cnt++;
            m_word_due   = cyc + 2;
        end
`ifdef FIFO_OVF_FLAG_EN
        if (cyc == m_word_due - 1) m_word[47] = m_ovf[m_ch];
`endif
        if (cyc == m_word_due) m_dv = 1'b1;
    endtask

    task automatic compare();
        chk("rdreq", 64'(bus.fifo_rdreq), 64'(m_rd));
        chk("data_valid", 64'(bus.data_valid), 64'(m_dv));
        chk("grant_ch", 64'(bus.grant_ch), 64'(m_ch));
        if (m_dv) chk("up_data", bus.up_data, m_word);
`ifdef FIFO_OVF_FLAG_EN
        chk("ovf_sticky", 64'(bus.ovf_sticky), 64'(m_ovf));
`endif
        if (bus.data_valid) begin
            dv_cycles++;
            if (dv_first < 0) dv_first = cyc;
        end
        if (bus.fifo_rdreq != 4'd0) begin
            rd_cycles++;
            if (rd_first < 0) rd_first = cyc;
        end
        rd_or = rd_or | bus.fifo_rdreq;
    endtask

    task automatic env_pop();
        for (int i = 0; i < 4; i++) begin
            if (bus.fifo_rdreq[i]) begin
                if (envq[i].size() == 0) begin
                    total++; bad++;
                    $display("FAIL rdreq_on_empty: got rdreq on ch%0d expected none (cycle %0d)", i, cyc);
                end else begin
                    pend_val[i] = envq[i].pop_front();
                    pend_pop[i] = 1'b1;
                end
            end
        end
    endtask

    // one clock: inputs are final at entry (negedge), returns at the next negedge after checking
    task automatic tick();
        for (int i = 0; i < 4; i++) bus.fifo_empty[i] = (envq[i].size() == 0);
        drv_emp = bus.fifo_empty;
        drv_arb = bus.arb_en;
`ifdef FIFO_OVF_FLAG_EN
        m_ovf = m_ovf | bus.fifo_full;
`endif
        if (bus.data_valid && bus.up_ready) acc_word.push_back(bus.up_data);
        if (m_dv && bus.up_ready) begin
            m_dv = 1'b0;
            if (bus.arb_en && m_cnt < BM && !bus.fifo_empty[m_ch]) begin
                m_pend_rd = cyc + 1;
            end else begin
                m_idle      = 1'b1;
                m_idle_from = cyc + 2;
                m_ptr       = 2'(int'(m_ch) + 1);
            end
        end
        @(posedge clk);
        #1;
        for (int i = 0; i < 4; i++) begin
            if (pend_pop[i]) begin
                qreg[i]     = pend_val[i];
                pend_pop[i] = 1'b0;
            end
        end
        @(negedge clk);
        cyc++;
        model_step();
        compare();
        env_pop();
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        #1;
        chk("rst_rdreq", 64'(bus.fifo_rdreq), 64'd0);
        chk("rst_valid", 64'(bus.data_valid), 64'd0);
        chk("rst_up_data", bus.up_data, 64'd0);
        chk("rst_grant", 64'(bus.grant_ch), 64'd0);
`ifdef FIFO_OVF_FLAG_EN
        chk("rst_ovf", 64'(bus.ovf_sticky), 64'd0);
`endif
        @(posedge clk);
        @(negedge clk);
        cyc++;
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            m_seq[i]    = 8'd0;
            pend_pop[i] = 1'b0;
        end
        m_ptr = 2'd0; m_ch = 2'd0; m_cnt = 0; m_idle = 1'b1; m_dv = 1'b0;
        m_idle_from = cyc + 1; m_pend_rd = -10; m_word_due = -10; m_ovf = '0; m_rd = '0;
    endtask

    task automatic drain(input int maxc);
        int n;
        bit busy;
        n = 0;
        bus.arb_en   = 1'b1;
        bus.up_ready = 1'b1;
        busy = 1'b1;
        while (busy && n < maxc) begin
            tick();
            n++;
            busy = !m_idle || m_dv || (m_word_due >= cyc);
            for (int i = 0; i < 4; i++) if (envq[i].size() != 0) busy = 1'b1;
        end
        if (busy) begin
            total++; bad++;
            $display("FAIL drain_timeout: still busy after %0d cycles, expected idle", maxc);
        end
        tick();
    endtask

    int          push_cyc;
    int          exp_ch  [7] = '{1, 1, 1, 1, 2, 1, 1};
    int          exp_seq [7] = '{0, 1, 2, 3, 0, 4, 5};
    logic [31:0] wb;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        bus.arb_en = 1'b0; bus.up_ready = 1'b0; bus.fifo_empty = 4'hF;
`ifdef FIFO_OVF_FLAG_EN
        bus.fifo_full = 4'd0;
`endif
        for (int i = 0; i < 4; i++) begin qreg[i] = '0; pend_pop[i] = 1'b0; pend_val[i] = '0; end
        clear_logs();
        @(negedge clk);
        do_reset();

        // single word on ch3
        clear_logs();
        bus.arb_en = 1'b1; bus.up_ready = 1'b1;
        push_cyc = cyc;
        push(2, 32'h0000_005C);
        drain(50);
        chk("t1_words", 64'(acc_word.size()), 64'd1);
        if (acc_word.size() > 0) chk("t1_word", acc_word[0], 64'hA55A_0200_0000_005C);
        chk("t1_rdreq_or", 64'(rd_or), 64'h4);
        chk("t1_rd_cycles", 64'(rd_cycles), 64'd1);
        chk("t1_dv_cycles", 64'(dv_cycles), 64'd1);
        chk("t1_rd_latency", 64'(rd_first - push_cyc), 64'd1);
        chk("t1_dv_latency", 64'(dv_first - rd_first), 64'd2);

        // one word in every channel
        do_reset();
        clear_logs();
        for (int i = 0; i < 4; i++) push(i, 32'h100 + 32'(i));
        drain(100);
        chk("t2_words", 64'(acc_word.size()), 64'd4);
        for (int i = 0; i < 4 && i < acc_word.size(); i++) begin
            chk("t2_order", 64'(acc_word[i][41:40]), 64'(i));
            chk("t2_seq", 64'(acc_word[i][39:32]), 64'd0);
        end

        // burst limit: ch2 six words, ch3 one word
        do_reset();
        clear_logs();
        for (int i = 0; i < 6; i++) push(1, $urandom);
        push(2, $urandom);
        drain(200);
        chk("t3_words", 64'(acc_word.size()), 64'd7);
        for (int i = 0; i < 7 && i < acc_word.size(); i++) begin
            chk("t3_order", 64'(acc_word[i][41:40]), 64'(exp_ch[i]));
            chk("t3_seq", 64'(acc_word[i][39:32]), 64'(exp_seq[i]));
        end

        // backpressure: up_ready low for 5 cycles while holding
        clear_logs();
        bus.up_ready = 1'b0;
        push(0, 32'hDEAD_BEEF);
        for (int k = 0; k < 10 && !bus.data_valid; k++) tick();
        chk("t4_hold_reached", 64'(bus.data_valid), 64'd1);
        for (int k = 0; k < 5; k++) begin
            tick();
            chk("t4_hold_data", bus.up_data, 64'hA55A_0000_DEAD_BEEF);
            chk("t4_hold_rdreq", 64'(bus.fifo_rdreq), 64'd0);
        end
        chk("t4_no_accept", 64'(acc_word.size()), 64'd0);
        bus.up_ready = 1'b1;
        tick();
        chk("t4_accept_once", 64'(acc_word.size()), 64'd1);
        drain(50);
        chk("t4_total", 64'(acc_word.size()), 64'd1);
        chk("t4_rd_cycles", 64'(rd_cycles), 64'd1);

        // sequence wrap across 257 words on ch1
        do_reset();
        clear_logs();
        for (int i = 0; i < 257; i++) push(0, $urandom);
        drain(2000);
        chk("t5_words", 64'(acc_word.size()), 64'd257);
        if (acc_word.size() == 257) begin
            chk("t5_seq255", 64'(acc_word[255][39:32]), 64'hFF);
            chk("t5_seq_wrap", 64'(acc_word[256][39:32]), 64'h00);
        end

        // reset while a word is held
        clear_logs();
        bus.up_ready = 1'b0;
        wb = 32'h1234_5678;
        push(0, 32'hAAAA_0001);
        push(0, wb);
        for (int k = 0; k < 10 && !bus.data_valid; k++) tick();
        chk("t6_hold_reached", 64'(bus.data_valid), 64'd1);
        do_reset();
        bus.up_ready = 1'b1;
        drain(50);
        chk("t6_words", 64'(acc_word.size()), 64'd1);
        if (acc_word.size() > 0) begin
            chk("t6_seq", 64'(acc_word[0][39:32]), 64'd0);
            chk("t6_data", 64'(acc_word[0][31:0]), 64'(wb));
        end

        // random traffic at the nominal channel rates, random ready and arb_en
        clear_logs();
        for (int k = 0; k < 4000; k++) begin
            if ($urandom_range(0, 19) == 0) push(0, $urandom);
            if ($urandom_range(0, 14) == 0) push(1, $urandom);
            if ($urandom_range(0, 49) == 0) push(2, $urandom);
            if ($urandom_range(0, 99) == 0) push(3, $urandom);
            bus.up_ready = ($urandom_range(0, 3) != 0);
            bus.arb_en   = ($urandom_range(0, 19) != 0);
            tick();
        end
        drain(2000);
        chk("t7_all_delivered", 64'(acc_word.size()), 64'(pushed));

        // overflow flag on ch4
        clear_logs();
`ifdef FIFO_OVF_FLAG_EN
        bus.fifo_full = 4'b1000;
        tick();
        bus.fifo_full = 4'b0000;
`endif
        push(3, 32'h0000_0077);
        drain(50);
        chk("t8_words", 64'(acc_word.size()), 64'd1);
`ifdef FIFO_OVF_FLAG_EN
        if (acc_word.size() > 0) chk("t8_ovf_bit", 64'(acc_word[0][47]), 64'd1);
        chk("t8_ovf_sticky", 64'(bus.ovf_sticky), 64'h8);
`else
        if (acc_word.size() > 0) chk("t8_ovf_bit", 64'(acc_word[0][47]), 64'd0);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/fifo4_rr_read_sched.md
Name: fifo4_rr_read_sched

Overview:
- Read-side scheduler for the four channel FIFOs (ch1..ch4) that feed the 64-bit upstream link.
- Watches each FIFO's empty flag and issues one-hot read requests, round-robin with a bounded burst per grant.
- Tags each word with a header, channel id and per-channel sequence number, and presents it on a valid/ready upstream interface.
- Sits between the four FIFO read ports and the uplink packer; it replaces free-running read logic.

Parameters:
- HDR_WORD, 16'hA55A, constant placed in up_data[63:48].
- BURST_MAX, 4, max words read from one channel per grant (legal 1..15).

Ports:
- ch1_wrclk  in  1  scheduler clock; also drives the FIFO read side.
- rst_n  in  1  reset.
- arb_en  in  1  1 = new grants allowed.
- fifo_empty  in  4  read-side empty flags; bit0 = ch1 … bit3 = ch4.
- fifo_q0..fifo_q3  in  32 each  FIFO read data; normal mode, valid 1 cycle after rdreq.
- fifo_rdreq  out  4  one-hot read request.
- up_ready  in  1  downstream accepts the word at a posedge when data_valid=1.
- data_valid  out  1  up_data valid.
- up_data  out  64  tagged word.
- grant_ch  out  2  channel currently or last granted.

Behaviour:
- Reset: rst_n is asynchronous, active-low; clock is ch1_wrclk. Reset clears fifo_rdreq=0, data_valid=0, up_data=0, grant_ch=0, all seq counters=0, burst_cnt=0, FSM=IDLE.
- The RR pointer resets so ch1 is checked first.
- up_data format:
  - [63:48] HDR_WORD
  - [47] ovf flag (0 unless macro enabled)
  - [46:42] 0
  - [41:40] channel id, 0..3 = ch1..ch4
  - [39:32] per-channel seq
  - [31:0] FIFO data
- FSM states: IDLE, READ, CAPT, HOLD.
- IDLE:
  - If arb_en=1 and any fifo_empty bit=0, pick the first non-empty channel starting after the last granted channel (modulo 4).
  - Set grant_ch, clear burst_cnt, go to READ. Otherwise stay.
- READ: fifo_rdreq[grant_ch]=1 for exactly one cycle, then go to CAPT.
- CAPT:
  - Register up_data from fifo_q[grant_ch] and the tags; set data_valid=1; go to HOLD.
  - Increment seq[grant_ch] (8-bit, 255 wraps to 0) and burst_cnt.
- HOLD:
  - data_valid=1; up_data and grant_ch are frozen until a posedge with up_ready=1. No rdreq is issued while in HOLD.
  - On accept, data_valid drops next cycle unless a new CAPT re-asserts it.
  - On accept: if arb_en=1, burst_cnt<BURST_MAX and fifo_empty[grant_ch]=0, go to READ. Otherwise go to IDLE and advance the pointer past grant_ch.
- Latency: with channel non-empty in IDLE, rdreq is high on the next cycle and data_valid is high 2 cycles after rdreq.
- Throughput:
  - Steady state with up_ready=1 is 1 word per 3 cycles.
  - This exceeds the aggregate test input rate (1/20+1/15+1/50+1/100 ≈ 0.147 words/cycle).
- Only one rdreq bit is ever high; never asserted on an empty FIFO.
- arb_en=0 mid-burst: the current word completes, then the FSM goes to IDLE and stays there.
- up_ready while data_valid=0 is ignored.
- Reset mid-operation: immediate return to reset values. A word in HOLD is lost and its seq is reset.

Optional Feature:
- Macro: FIFO_OVF_FLAG_EN.
- Defined:
  - Adds input fifo_full[3:0] (bit0 = ch1) and output ovf_sticky[3:0].
  - ovf_sticky[i] sets on any posedge with fifo_full[i]=1 and clears only on reset.
  - up_data[47] = ovf_sticky[grant_ch] sampled in CAPT.
- Undefined: these ports do not exist; up_data[47]=0.

Test Plan:
- One write 0x5C into ch3 FIFO, up_ready=1 → single rdreq=4'b0100; up_data=64'hA55A_0200_0000_005C; data_valid high 1 cycle.
- ch1..ch4 each hold 1 word after reset → grant order 0,1,2,3; seq=0 in each word.
- ch2 holds 6 words, ch3 holds 1 word → grant order ch2 ×4 (seq 0..3), ch3 ×1, ch2 ×2 (seq 4..5).
- up_ready=0 for 5 cycles during HOLD → data_valid and up_data stable, fifo_rdreq=0 throughout; word accepted once on the first cycle up_ready=1.
- 257 words through ch1 → seq 0..255 then 0x00 on the 257th word. Mid-burst: rst_n low 1 cycle in HOLD → outputs go to 0 immediately; next word has seq 0.
- FIFO_OVF_FLAG_EN: pulse fifo_full[3] for 1 cycle, then a ch4 word → up_data[47]=1, ovf_sticky=4'b1000; without the macro, bit 47=0.
